// File: rtl/scs8hd_mux4_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scs8hd_mux4_arb_pkg
// Description : Shared definitions for the 4:1 mux select arbiter: FSM state
//               encoding, requester count, counter widths and a one-hot
//               decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package scs8hd_mux4_arb_pkg;

    localparam int c_num_req  = 4;
    localparam int c_settle_w = 4;
    localparam int c_hold_w   = 8;

    localparam logic [c_hold_w-1:0] c_hold_sat = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_GRANT  = 2'b10
    } state_e;

    // Decode a 2-bit requester index into a one-hot 4-bit vector.
    function automatic logic [c_num_req-1:0] f_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage : scs8hd_mux4_arb_pkg
`default_nettype wire

// File: rtl/scs8hd_rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : scs8hd_rr_pick4
// Description : Combinational round-robin picker. Returns the first asserted
//               request at or after (last+1) mod 4, wrapping so that the
//               previous owner is considered last.
// Ports       : req   [3:0] in  - request vector
//               last  [1:0] in  - index of the most recent owner
//               valid       out - at least one request is asserted
//               idx   [1:0] out - selected requester (0 when valid is low)
// Revision    : 1.0 - initial release
// ============================================================================
module scs8hd_rr_pick4
    import scs8hd_mux4_arb_pkg::*;
(
    input  logic [c_num_req-1:0] req,
    input  logic [1:0]           last,
    output logic                 valid,
    output logic [1:0]           idx
);

    logic [1:0] w_cand;

    // Offsets 1..4 walk the ring starting just after the last owner; the
    // 2-bit add wraps naturally, and offset 4 lands back on the last owner.
    always_comb begin
        valid  = 1'b0;
        idx    = 2'd0;
        w_cand = 2'd0;
        for (int k = 1; k <= c_num_req; k++) begin
            w_cand = last + k[1:0];
            if (!valid && req[w_cand]) begin
                valid = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule : scs8hd_rr_pick4
`default_nettype wire

// File: rtl/scs8hd_mux4_arb.sv
`default_nettype none
// ============================================================================
// Module      : scs8hd_mux4_arb
// Description : Round-robin arbiter driving the select lines of a 4:1 mux.
//               The select is loaded first and held stable for SETTLE_CYC
//               cycles before the grant asserts; an owner held longer than
//               MAX_HOLD cycles is pre-empted when someone else is waiting.
// Parameters  : SETTLE_CYC (1..15)  select-to-grant settle cycles
//               MAX_HOLD   (0..255) pre-emption threshold, 0 = never
// Ports       : CLK        in  - clock, rising edge
//               RESETB     in  - asynchronous active-low reset
//               REQ  [3:0] in  - per-requester request (level)
//               GNT  [3:0] out - registered one-hot grant
//               S0, S1     out - registered mux select LSB / MSB
//               BUSY       out - registered, high outside IDLE
//               vpwr/vgnd/vpb/vnb in - supply pins when SC_USE_PG_PIN is set
// Revision    : 1.0 - initial release
// ============================================================================
module scs8hd_mux4_arb
    import scs8hd_mux4_arb_pkg::*;
#(
    parameter int SETTLE_CYC = 1,
    parameter int MAX_HOLD   = 16
) (
`ifdef SC_USE_PG_PIN
    input  logic                 vpwr,
    input  logic                 vgnd,
    input  logic                 vpb,
    input  logic                 vnb,
`endif
    input  logic                 CLK,
    input  logic                 RESETB,
    input  logic [c_num_req-1:0] REQ,
    output logic [c_num_req-1:0] GNT,
    output logic                 S0,
    output logic                 S1,
    output logic                 BUSY
);

`ifndef SC_USE_PG_PIN
    supply1 vpwr;
    supply1 vpb;
    supply0 vgnd;
    supply0 vnb;
`endif

    localparam logic [c_settle_w-1:0] c_settle_ld  = SETTLE_CYC[c_settle_w-1:0];
    localparam logic [c_hold_w-1:0]   c_max_hold   = MAX_HOLD[c_hold_w-1:0];
    localparam bit                    c_preempt_en = (MAX_HOLD != 0);

    // With the supplies tied internally this reduces to RESETB; with real
    // supply pins the block is held in reset until power is good.
    logic w_pwr_good;
    logic w_rst_n;
    assign w_pwr_good = vpwr & vpb & ~vgnd & ~vnb;
    assign w_rst_n    = RESETB & w_pwr_good;

    state_e                r_state_q,  w_state_d;
    logic [1:0]            r_sel_q,    w_sel_d;
    logic [1:0]            r_last_q,   w_last_d;
    logic [c_num_req-1:0]  r_gnt_q,    w_gnt_d;
    logic                  r_busy_q,   w_busy_d;
    logic [c_settle_w-1:0] r_settle_q, w_settle_d;
    logic [c_hold_w-1:0]   r_hold_q,   w_hold_d;

    logic       w_pick_valid;
    logic [1:0] w_pick_idx;
    logic       w_owner_req;
    logic       w_others_req;
    logic       w_hold_expired;

    scs8hd_rr_pick4 u_pick (
        .req   (REQ),
        .last  (r_last_q),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    assign w_owner_req    = REQ[r_sel_q];
    assign w_others_req   = |(REQ & ~f_onehot(r_sel_q));
    assign w_hold_expired = c_preempt_en && (r_hold_q >= c_max_hold);

    always_comb begin
        w_state_d  = r_state_q;
        w_sel_d    = r_sel_q;
        w_last_d   = r_last_q;
        w_gnt_d    = r_gnt_q;
        w_settle_d = r_settle_q;
        w_hold_d   = r_hold_q;

        case (r_state_q)
            ST_IDLE: begin
                w_gnt_d    = '0;
                w_hold_d   = '0;
                w_settle_d = '0;
                if (w_pick_valid) begin
                    w_sel_d    = w_pick_idx;
                    w_settle_d = c_settle_ld;
                    w_state_d  = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                w_gnt_d = '0;
                if (!w_owner_req) begin
                    // Aborted before grant: LAST stays, so the ring position
                    // is not advanced by a requester that never owned the mux.
                    w_settle_d = '0;
                    w_state_d  = ST_IDLE;
                end else if (r_settle_q <= 4'd1) begin
                    w_gnt_d    = f_onehot(r_sel_q);
                    w_hold_d   = 8'd1;
                    w_settle_d = '0;
                    w_state_d  = ST_GRANT;
                end else begin
                    w_settle_d = r_settle_q - 4'd1;
                end
            end

            ST_GRANT: begin
                if (!w_owner_req || (w_hold_expired && w_others_req)) begin
                    w_gnt_d   = '0;
                    w_last_d  = r_sel_q;
                    w_hold_d  = '0;
                    w_state_d = ST_IDLE;
                end else if (r_hold_q != c_hold_sat) begin
                    w_hold_d = r_hold_q + 8'd1;
                end
            end

            default: begin
                w_gnt_d    = '0;
                w_hold_d   = '0;
                w_settle_d = '0;
                w_state_d  = ST_IDLE;
            end
        endcase

        w_busy_d = (w_state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state_q  <= ST_IDLE;
            r_sel_q    <= 2'd0;
            r_last_q   <= 2'd3;
            r_gnt_q    <= '0;
            r_busy_q   <= 1'b0;
            r_settle_q <= '0;
            r_hold_q   <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_sel_q    <= w_sel_d;
            r_last_q   <= w_last_d;
            r_gnt_q    <= w_gnt_d;
            r_busy_q   <= w_busy_d;
            r_settle_q <= w_settle_d;
            r_hold_q   <= w_hold_d;
        end
    end

    assign GNT  = r_gnt_q;
    assign S0   = r_sel_q[0];
    assign S1   = r_sel_q[1];
    assign BUSY = r_busy_q;

endmodule : scs8hd_mux4_arb
`default_nettype wire

// File: doc/scs8hd_mux4_arb.md
SCS8HD_MUX4_ARB -- requirements
Module: scs8hd_mux4_arb

Interface
REQ-001 The module SHALL take parameter SETTLE_CYC, default 1: number of cycles the select lines are held stable before a grant asserts (range 1..15).
REQ-002 The module SHALL take parameter MAX_HOLD, default 16: grant cycles after which an owner is pre-empted if others wait (0 disables pre-emption; range 0..255).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESETB  input  1  asynchronous, active-low reset.
REQ-005 REQ  input  4  per-requester request, bit i selects mux input Ai; held high for the whole ownership.
REQ-006 GNT  output  4  one-hot grant, registered; at most one bit high.
REQ-007 S0  output  1  registered mux select LSB, drives the 4:1 mux S0.
REQ-008 S1  output  1  registered mux select MSB, drives the 4:1 mux S1.
REQ-009 BUSY  output  1  high in any state other than IDLE.
REQ-010 With SC_USE_PG_PIN defined, the module SHALL add inputs vpwr, vgnd, vpb, vnb; otherwise these SHALL be internal supply1/supply0 nets.

Function
REQ-011 The controller SHALL be a 3-state FSM: IDLE, SETTLE, GRANT.
REQ-012 IDLE: if any REQ bit is high, the controller SHALL pick the first requester at or after (LAST+1) mod 4, load {S1,S0} with its index, load the settle counter with SETTLE_CYC, and enter SETTLE on the next edge.
REQ-013 IDLE with REQ==0 SHALL hold S1/S0 at their last values and GNT at 0.
REQ-014 SETTLE: the settle counter SHALL decrement each cycle; GNT SHALL stay 0; at count 1 the controller SHALL assert GNT[owner] and enter GRANT on the next edge.
REQ-015 SETTLE: if REQ[owner] falls, the controller SHALL return to IDLE next edge without granting and without updating LAST.
REQ-016 GRANT: S1/S0 SHALL NOT change; an 8-bit hold counter SHALL start at 1 on entry and saturate at 255.
REQ-017 GRANT: when REQ[owner] falls, GNT SHALL clear on the next edge, LAST SHALL become owner, and the state SHALL become IDLE.
REQ-018 GRANT: when MAX_HOLD!=0, hold counter >= MAX_HOLD and any other REQ bit is high, GNT SHALL clear on the next edge, LAST SHALL become owner, and the state SHALL become IDLE (pre-emption).
REQ-019 Pre-emption SHALL NOT occur when no other requester is pending, regardless of hold count.
REQ-020 Minimum grant-to-grant gap SHALL be SETTLE_CYC+1 cycles (one IDLE cycle plus SETTLE).
REQ-021 Requests arriving while another owner holds GRANT SHALL be queued implicitly (level-sensitive) and served in round-robin order.
REQ-022 Round-robin order SHALL guarantee every continuously asserted request a grant within 3 foreign ownerships.

Reset
REQ-023 RESETB low SHALL immediately force state IDLE, GNT=0, S0=0, S1=0, BUSY=0, counters=0, LAST=3 (first grant goes to requester 0), including mid-SETTLE or mid-GRANT.
REQ-024 Reset deassertion SHALL be sampled synchronously; the first arbitration SHALL occur on the first edge after RESETB rises.

Structure
REQ-025 A shared package scs8hd_mux4_arb_pkg SHALL hold the state encoding (IDLE=2'b00, SETTLE=2'b01, GRANT=2'b10), requester count 4, and counter widths (settle 4, hold 8).
REQ-026 The round-robin selector SHALL be one combinational sub-module scs8hd_rr_pick4 (inputs req[3:0], last[1:0]; outputs valid, idx[1:0]).
REQ-027 All outputs SHALL come directly from flops; no combinational path from REQ to GNT/S0/S1.

Verification
REQ-028 Reset then REQ=4'b0001 held -> S1S0=00 after 1 edge, GNT=0001 after SETTLE_CYC+1 edges, BUSY=1.
REQ-029 REQ=4'b1111 held, MAX_HOLD=4 -> grants 0,1,2,3,0 in order, each GNT high exactly 4 cycles, 2-cycle gap between grants.
REQ-030 Owner 2 alone, MAX_HOLD=4, REQ held 20 cycles -> GNT=0100 continuous for 20 cycles, no pre-emption.
REQ-031 REQ[1] drops during SETTLE with REQ[3] high -> no GNT[1] pulse, next grant GNT=1000, LAST unaffected by aborted requester.
REQ-032 RESETB pulsed low mid-GRANT (owner 3) -> GNT=0, S1S0=00 in the same cycle asynchronously; after release with REQ=1111 first grant is 0001.
REQ-033 Random REQ traffic 10k cycles -> GNT always one-hot or zero, S1S0 never changes while GNT!=0, GNT index equals {S1,S0}.
